// File: rtl/modbus_frame_tx_seq.sv
// Modbus RTU response frame sequencer: streams payload bytes from the frame buffer into
// uart_byte_tx and holds the T3.5 silence before reporting done. CRC append: MODBUS_CRC_APPEND_EN.
module modbus_frame_tx_seq #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned GAP_BITS  = 39
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic [8:0] frame_len,
    output logic       busy,
    output logic       frame_done,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done
);

    localparam int unsigned BIT_CYC    = CLK_FREQ / BAUD_RATE;
    localparam int unsigned GAP_CYCLES = GAP_BITS * BIT_CYC;
    localparam int unsigned GapW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        StIdle, StFetch, StLoad, StWaitTx, StCrcLo, StCrcHi, StGap, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      last_q, last_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            start_ok;

    assign start_ok = frame_start && (frame_len != 9'd0);

`ifdef MODBUS_CRC_APPEND_EN
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_sh_q, crc_sh_d;
    logic [3:0]  crc_bits_q, crc_bits_d;
    logic        crc_fb;

    // One bit per clock while the UART is busy shifting the byte out.
    always_comb begin
        crc_d      = crc_q;
        crc_sh_d   = crc_sh_q;
        crc_bits_d = crc_bits_q;
        crc_fb     = crc_q[0] ^ crc_sh_q[0];
        if (state_q == StIdle && start_ok) begin
            crc_d = 16'hFFFF;
        end else if (state_q == StLoad) begin
            crc_sh_d   = rd_data;
            crc_bits_d = 4'd0;
        end else if (state_q == StWaitTx && crc_bits_q != 4'd8) begin
            crc_d      = {1'b0, crc_q[15:1]} ^ (crc_fb ? 16'hA001 : 16'h0000);
            crc_sh_d   = {1'b0, crc_sh_q[7:1]};
            crc_bits_d = crc_bits_q + 4'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q      <= 16'hFFFF;
            crc_sh_q   <= 8'h00;
            crc_bits_q <= 4'd0;
        end else begin
            crc_q      <= crc_d;
            crc_sh_q   <= crc_sh_d;
            crc_bits_q <= crc_bits_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        gap_d      = gap_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    last_d  = (frame_len > 9'd256) ? 8'd255 : 8'(frame_len - 9'd1);
                    idx_d   = 8'd0;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                tx_data_d  = rd_data;
                tx_start_d = 1'b1;
                state_d    = StWaitTx;
            end
            StWaitTx: begin
                if (tx_done) begin
                    if (idx_q != last_q) begin
                        idx_d   = idx_q + 8'd1;
                        state_d = StFetch;
                    end else begin
`ifdef MODBUS_CRC_APPEND_EN
                        tx_data_d  = crc_q[7:0];
                        tx_start_d = 1'b1;
                        state_d    = StCrcLo;
`else
                        gap_d   = '0;
                        state_d = StGap;
`endif
                    end
                end
            end
`ifdef MODBUS_CRC_APPEND_EN
            StCrcLo: begin
                if (tx_done) begin
                    tx_data_d  = crc_q[15:8];
                    tx_start_d = 1'b1;
                    state_d    = StCrcHi;
                end
            end
            StCrcHi: begin
                if (tx_done) begin
                    gap_d   = '0;
                    state_d = StGap;
                end
            end
`endif
            StGap: begin
                if (gap_q == GapW'(GAP_CYCLES - 1)) begin
                    state_d = StDone;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            idx_q      <= 8'd0;
            last_q     <= 8'd0;
            gap_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            gap_q      <= gap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign frame_done = (state_q == StDone);
    assign rd_en      = (state_q == StFetch);
    assign rd_addr    = idx_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_modbus_frame_tx_seq.sv
// Bench for modbus_frame_tx_seq: frame table plus reset-abort and ignored-request sequences,
// with a byte scoreboard fed by a simple uart_byte_tx stand-in.
`timescale 1ns/1ps
module tb_modbus_frame_tx_seq;

    localparam int GapCycles = 16926;
    localparam int TxLat     = 12;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [8:0] frame_len = 9'd0;
    logic       busy, frame_done, rd_en, tx_start, tx_done;
    logic [7:0] rd_addr, rd_data, tx_data;

    modbus_frame_tx_seq dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .busy        (busy),
        .frame_done  (frame_done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [7:0] mem [256];
    always @(posedge sys_clk) if (rd_en) rd_data <= mem[rd_addr];

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];
    int         start_cycs [$];
    int         n_done = 0;
    int         last_done_cyc = 0;
    logic       pend = 1'b0;
    int         cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input int unsigned n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < int'(n); i++) begin
            c = c ^ {8'h00, mem[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // uart_byte_tx stand-in and scoreboard consumer
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            tx_done = 1'b0;
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        tx_done = 1'b1;
                        pend = 1'b0;
                        last_done_cyc = cyc;
                    end else begin
                        cnt--;
                    end
                end
                if (tx_start) begin
                    check("tx_start_overlap", 32'(pend), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_tx_start: got byte %0h, required none", tx_data);
                    end else begin
                        check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
                    end
                    start_cycs.push_back(cyc);
                    pend = 1'b1;
                    cnt = TxLat;
                end
                if (frame_done) n_done++;
            end
        end
    end

    task automatic run_frame(input logic [8:0] len_req, input int unsigned len_eff,
                             input logic [15:0] crc_exp);
        int s_cyc, nd0, n_exp;
        bit found;
        start_cycs.delete();
        exp_q.delete();
        nd0 = n_done;
        for (int i = 0; i < int'(len_eff); i++) exp_q.push_back(mem[i]);
        n_exp = int'(len_eff);
`ifdef MODBUS_CRC_APPEND_EN
        exp_q.push_back(crc_exp[7:0]);
        exp_q.push_back(crc_exp[15:8]);
        n_exp += 2;
`endif
        @(negedge sys_clk);
        frame_start = 1'b1;
        frame_len = len_req;
        s_cyc = cyc;
        @(negedge sys_clk);
        frame_start = 1'b0;
        check("busy_on_accept", 32'(busy), 32'd1);
        // A second request mid-frame must not disturb anything.
        repeat (40) @(negedge sys_clk);
        frame_start = 1'b1;
        frame_len = 9'd2;
        @(negedge sys_clk);
        frame_start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 40000; t++) begin
            @(negedge sys_clk);
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_done_timeout: got no frame_done, required one within 40000 cycles");
        end else begin
            check("busy_low_at_done", 32'(busy), 32'd0);
            check("gap_after_last_tx_done", 32'(cyc - last_done_cyc), 32'(GapCycles + 1));
        end
        if (start_cycs.size() > 0)
            check("first_tx_start_latency", 32'(start_cycs[0] - s_cyc), 32'd3);
        @(negedge sys_clk);
        check("bytes_left_in_scoreboard", 32'(exp_q.size()), 32'd0);
        check("tx_start_count", 32'(start_cycs.size()), 32'(n_exp));
        check("frame_done_count", 32'(n_done), 32'(nd0 + 1));
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [8:0]  len_req;
        int unsigned len_eff;
        bit          incr;
        logic [7:0]  data [6];
        bit          use_const;
        logic [15:0] crc;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [15:0] crc;
        int          nd0;
        bit          seen;

        vecs[0].len_req = 9'd6;   vecs[0].len_eff = 6;   vecs[0].incr = 1'b0;
        vecs[0].data = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        vecs[0].use_const = 1'b1; vecs[0].crc = 16'h0A84;
        vecs[1].len_req = 9'd1;   vecs[1].len_eff = 1;   vecs[1].incr = 1'b0;
        vecs[1].data = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].use_const = 1'b0; vecs[1].crc = 16'h0000;
        vecs[2].len_req = 9'd300; vecs[2].len_eff = 256; vecs[2].incr = 1'b1;
        vecs[2].data = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].use_const = 1'b0; vecs[2].crc = 16'h0000;

        repeat (3) @(negedge sys_clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_rd_en", 32'(rd_en), 32'd0);
        check("reset_rd_addr", 32'(rd_addr), 32'd0);
        check("reset_tx_start", 32'(tx_start), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 256; i++) begin
                if (vecs[v].incr) mem[i] = 8'(i);
                else if (i < 6)   mem[i] = vecs[v].data[i];
                else              mem[i] = 8'h00;
            end
            crc = vecs[v].use_const ? vecs[v].crc : crc_model(vecs[v].len_eff);
            run_frame(vecs[v].len_req, vecs[v].len_eff, crc);
        end

        // Zero-length request is dropped.
        nd0 = n_done;
        @(negedge sys_clk);
        frame_start = 1'b1;
        frame_len = 9'd0;
        @(negedge sys_clk);
        frame_start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (busy || rd_en || frame_done) seen = 1'b1;
            @(negedge sys_clk);
        end
        check("len0_ignored_activity", 32'(seen), 32'd0);
        check("len0_no_frame_done", 32'(n_done), 32'(nd0));

        // Abort during the third byte, then a fresh frame.
        mem[0] = 8'h55; mem[1] = 8'h66; mem[2] = 8'h77;
        mem[3] = 8'h88; mem[4] = 8'h99; mem[5] = 8'hAA;
        exp_q.delete();
        start_cycs.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(mem[i]);
        nd0 = n_done;
        @(negedge sys_clk);
        frame_start = 1'b1;
        frame_len = 9'd6;
        @(negedge sys_clk);
        frame_start = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            if (start_cycs.size() >= 3) break;
            @(negedge sys_clk);
        end
        check("abort_reached_byte3", 32'(start_cycs.size()), 32'd3);
        repeat (2) @(negedge sys_clk);
        #1 reset_n = 1'b0;
        @(negedge sys_clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(rd_en), 32'd0);
        check("abort_rd_addr", 32'(rd_addr), 32'd0);
        check("abort_tx_start", 32'(tx_start), 32'd0);
        check("abort_tx_data", 32'(tx_data), 32'd0);
        repeat (3) @(negedge sys_clk);
        exp_q.delete();
        #1 reset_n = 1'b1;
        repeat (30) @(negedge sys_clk);
        check("abort_no_frame_done", 32'(n_done), 32'(nd0));

        mem[0] = 8'h11;
        mem[1] = 8'h22;
        run_frame(9'd2, 2, crc_model(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got no completion, required finish within 3 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
